lift_call_dispatcher: RTL and testbench

Hall-call side of the lift interface. It latches up/down hall button presses from every floor into pending-call registers and drives the lift controller's floor-request inputs (the up/down floor numbers) one call at a time. It picks each call in SCAN order and holds the request until the lift reports arrival by opening its door. It sits between the floor button panels and the lift controller, and drives the hall-lamp outputs.

---
 rtl/lift_pkg.sv | 27 ++
 rtl/lift_call_picker.sv | 94 +++++++++
 rtl/lift_call_dispatcher.sv | 176 +++++++++++++++++
 tb/tb_lift_call_dispatcher.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
`default_nettype none
// ============================================================================
// Package     : lift_pkg
// Description : Shared types and default sizes for the hall-call dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
package lift_pkg;

    localparam int DEFAULT_NUM_FLOORS = 32;
    localparam int DEFAULT_FLOOR_W    = 5;

    // Dispatch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_SELECT      = 2'd1,
        ST_WAIT_ARRIVE = 2'd2,
        ST_CLEAR       = 2'd3
    } disp_state_t;

    // Travel direction, also used as the type of a hall call
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage
`default_nettype wire

// File: rtl/lift_call_picker.sv
`default_nettype none
// ============================================================================
// Module      : lift_call_picker
// Description : Combinational SCAN selection of the next hall call to serve.
// Revision    : 1.0 - initial release
// ============================================================================
module lift_call_picker
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS,
    parameter int FLOOR_W    = DEFAULT_FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] pend_up_i,
    input  logic [NUM_FLOORS-1:0] pend_down_i,
    input  logic [FLOOR_W-1:0]    cur_floor_i,
    input  dir_t                  dir_i,
    output logic [FLOOR_W-1:0]    tgt_o,
    output dir_t                  tgt_type_o,
    output dir_t                  new_dir_o,
    output logic                  valid_o
);

    logic               up_ge_hit, up_lo_hit, dn_le_hit, dn_hi_hit;
    logic [FLOOR_W-1:0] up_ge_f, up_lo_f, dn_le_f, dn_hi_f;

    // Extreme-floor candidates; floor 0 never qualifies as a call
    always_comb begin
        up_ge_hit = 1'b0;
        up_lo_hit = 1'b0;
        dn_le_hit = 1'b0;
        dn_hi_hit = 1'b0;
        up_ge_f   = '0;
        up_lo_f   = '0;
        dn_le_f   = '0;
        dn_hi_f   = '0;
        // Descending scan: the last hit is the lowest matching floor
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            if ((f != 0) && pend_up_i[f]) begin
                up_lo_hit = 1'b1;
                up_lo_f   = FLOOR_W'(f);
                if (FLOOR_W'(f) >= cur_floor_i) begin
                    up_ge_hit = 1'b1;
                    up_ge_f   = FLOOR_W'(f);
                end
            end
        end
        // Ascending scan: the last hit is the highest matching floor
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if ((f != 0) && pend_down_i[f]) begin
                dn_hi_hit = 1'b1;
                dn_hi_f   = FLOOR_W'(f);
                if (FLOOR_W'(f) <= cur_floor_i) begin
                    dn_le_hit = 1'b1;
                    dn_le_f   = FLOOR_W'(f);
                end
            end
        end
    end

    // SCAN priority: keep sweeping, reverse at the far end, then wrap
    always_comb begin
        tgt_o      = '0;
        tgt_type_o = DIR_UP;
        new_dir_o  = dir_i;
        valid_o    = up_lo_hit | dn_hi_hit;
        if (dir_i == DIR_UP) begin
            if (up_ge_hit) begin
                tgt_o      = up_ge_f;
                tgt_type_o = DIR_UP;
            end else if (dn_hi_hit) begin
                tgt_o      = dn_hi_f;
                tgt_type_o = DIR_DOWN;
                new_dir_o  = DIR_DOWN;
            end else if (up_lo_hit) begin
                tgt_o      = up_lo_f;
                tgt_type_o = DIR_UP;
            end
        end else begin
            if (dn_le_hit) begin
                tgt_o      = dn_le_f;
                tgt_type_o = DIR_DOWN;
            end else if (up_lo_hit) begin
                tgt_o      = up_lo_f;
                tgt_type_o = DIR_UP;
                new_dir_o  = DIR_UP;
            end else if (dn_hi_hit) begin
                tgt_o      = dn_hi_f;
                tgt_type_o = DIR_DOWN;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lift_call_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : lift_call_dispatcher
// Description : Latches hall calls and issues them one at a time, in SCAN
//               order, to the lift controller; drives the hall lamps.
// Revision    : 1.0 - initial release
// ============================================================================
module lift_call_dispatcher
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS,
    parameter int FLOOR_W    = DEFAULT_FLOOR_W,
    parameter int TIMEOUT    = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_FLOORS-1:0] i_hall_up,
    input  logic [NUM_FLOORS-1:0] i_hall_down,
    input  logic                  i_lift_ready,
    input  logic                  i_door_open,
    output logic [FLOOR_W-1:0]    o_up,
    output logic [FLOOR_W-1:0]    o_down,
    output logic [NUM_FLOORS-1:0] o_up_lamp,
    output logic [NUM_FLOORS-1:0] o_down_lamp,
    output logic                  o_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [NUM_FLOORS-1:0] C_FLOOR0 = NUM_FLOORS'(1);

    disp_state_t           state_q, state_d;
    dir_t                  dir_q, dir_d;
    dir_t                  tgt_type_q, tgt_type_d;
    logic [FLOOR_W-1:0]    cur_floor_q, cur_floor_d;
    logic [FLOOR_W-1:0]    tgt_q, tgt_d;
    logic [FLOOR_W-1:0]    up_q, up_d;
    logic [FLOOR_W-1:0]    down_q, down_d;
    logic [NUM_FLOORS-1:0] pend_up_q, pend_up_d;
    logic [NUM_FLOORS-1:0] pend_down_q, pend_down_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  door_q;
    logic                  timeout_q, timeout_d;

    logic [FLOOR_W-1:0]    pick_tgt;
    dir_t                  pick_type;
    dir_t                  pick_dir;
    logic                  pick_valid;
    logic                  arrive;
    logic [NUM_FLOORS-1:0] clr_up, clr_down;

    lift_call_picker #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_picker (
        .pend_up_i   (pend_up_q),
        .pend_down_i (pend_down_q),
        .cur_floor_i (cur_floor_q),
        .dir_i       (dir_q),
        .tgt_o       (pick_tgt),
        .tgt_type_o  (pick_type),
        .new_dir_o   (pick_dir),
        .valid_o     (pick_valid)
    );

    // Door rising edge is the lift's arrival acknowledgement
    assign arrive = i_door_open & ~door_q;

    // Next-state, request buses, service clears and pending-call latching
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        tgt_type_d  = tgt_type_q;
        cur_floor_d = cur_floor_q;
        tgt_d       = tgt_q;
        up_d        = up_q;
        down_d      = down_q;
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
        clr_up      = '0;
        clr_down    = '0;

        case (state_q)
            ST_IDLE: begin
                if (((|pend_up_q) || (|pend_down_q)) && i_lift_ready) begin
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (pick_valid) begin
                    tgt_d      = pick_tgt;
                    tgt_type_d = pick_type;
                    dir_d      = pick_dir;
                    cnt_d      = '0;
                    up_d       = (pick_type == DIR_UP)   ? pick_tgt : '0;
                    down_d     = (pick_type == DIR_DOWN) ? pick_tgt : '0;
                    state_d    = ST_WAIT_ARRIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_ARRIVE: begin
                // Arrival takes precedence over an expiring timer
                if (arrive) begin
                    if (tgt_type_q == DIR_UP) begin
                        clr_up = C_FLOOR0 << tgt_q;
                    end else begin
                        clr_down = C_FLOOR0 << tgt_q;
                    end
                    cur_floor_d = tgt_q;
                    up_d        = '0;
                    down_d      = '0;
                    state_d     = ST_CLEAR;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    up_d      = '0;
                    down_d    = '0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CLEAR: begin
                // Let the door close so its next rise is a fresh arrival
                if (!i_door_open) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A service clear beats a press on the same bit; floor 0 never latches
        pend_up_d   = (pend_up_q   | i_hall_up)   & ~clr_up   & ~C_FLOOR0;
        pend_down_d = (pend_down_q | i_hall_down) & ~clr_down & ~C_FLOOR0;
    end

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_UP;
            tgt_type_q  <= DIR_UP;
            cur_floor_q <= '0;
            tgt_q       <= '0;
            up_q        <= '0;
            down_q      <= '0;
            pend_up_q   <= '0;
            pend_down_q <= '0;
            cnt_q       <= '0;
            door_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            tgt_type_q  <= tgt_type_d;
            cur_floor_q <= cur_floor_d;
            tgt_q       <= tgt_d;
            up_q        <= up_d;
            down_q      <= down_d;
            pend_up_q   <= pend_up_d;
            pend_down_q <= pend_down_d;
            cnt_q       <= cnt_d;
            door_q      <= i_door_open;
            timeout_q   <= timeout_d;
        end
    end

    assign o_up        = up_q;
    assign o_down      = down_q;
    assign o_up_lamp   = pend_up_q;
    assign o_down_lamp = pend_down_q;
    assign o_timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_lift_call_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_lift_call_dispatcher
// Description : Directed bench for lift_call_dispatcher with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lift_call_dispatcher;

    localparam int NF   = 32;
    localparam int FW   = 5;
    localparam int TOUT = 16;

    logic          clk;
    logic          rst_n;
    logic [NF-1:0] hall_up, hall_down;
    logic          ready, door;
    logic [FW-1:0] o_up, o_down;
    logic [NF-1:0] o_up_lamp, o_down_lamp;
    logic          o_timeout;

    int n_pass  = 0;
    int n_total = 0;
    bit armed   = 1'b0;

    lift_call_dispatcher #(
        .NUM_FLOORS (NF),
        .FLOOR_W    (FW),
        .TIMEOUT    (TOUT)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_hall_up    (hall_up),
        .i_hall_down  (hall_down),
        .i_lift_ready (ready),
        .i_door_open  (door),
        .o_up         (o_up),
        .o_down       (o_down),
        .o_up_lamp    (o_up_lamp),
        .o_down_lamp  (o_down_lamp),
        .o_timeout    (o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Pending calls as bitmaps; a request is "in flight" from issue until the
    // door rises or TOUT cycles have elapsed since issue.
    bit [NF-1:0] m_pu, m_pd, nu, nd;
    int          m_cur, m_tgt, m_phase, m_cyc, m_issue, pk_t;
    bit          m_down_dir, m_tgt_up, m_to, m_door_prev, rise, pk_up, pk_dn;
    logic [FW-1:0] m_up, m_down;

    task automatic scan_pick(input bit [NF-1:0] pu, input bit [NF-1:0] pd, input int cur,
                             input bit down_dir, output int tgt, output bit is_up,
                             output bit new_down);
        int lo_up, ge_up, hi_dn, le_dn;
        lo_up = -1; ge_up = -1; hi_dn = -1; le_dn = -1;
        for (int f = 1; f < NF; f++) begin
            if (pu[f] && lo_up < 0) lo_up = f;
            if (pu[f] && f >= cur && ge_up < 0) ge_up = f;
            if (pd[f]) hi_dn = f;
            if (pd[f] && f <= cur) le_dn = f;
        end
        new_down = down_dir;
        is_up    = 1'b1;
        tgt      = 0;
        if (!down_dir) begin
            if (ge_up > 0) tgt = ge_up;
            else if (hi_dn > 0) begin tgt = hi_dn; is_up = 1'b0; new_down = 1'b1; end
            else tgt = lo_up;
        end else begin
            if (le_dn > 0) begin tgt = le_dn; is_up = 1'b0; end
            else if (lo_up > 0) begin tgt = lo_up; new_down = 1'b0; end
            else begin tgt = hi_dn; is_up = 1'b0; end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pu = '0; m_pd = '0; m_cur = 0; m_down_dir = 1'b0; m_phase = 0;
            m_tgt = 0; m_tgt_up = 1'b1; m_up = '0; m_down = '0; m_to = 1'b0;
            m_door_prev = 1'b0; m_cyc = 0; m_issue = 0;
        end else begin
            m_cyc++;
            nu   = m_pu | hall_up;
            nd   = m_pd | hall_down;
            rise = door && !m_door_prev;
            m_to = 1'b0;
            case (m_phase)
                0: if ((m_pu | m_pd) != '0 && ready) m_phase = 1;
                1: begin
                    scan_pick(m_pu, m_pd, m_cur, m_down_dir, pk_t, pk_up, pk_dn);
                    m_tgt = pk_t; m_tgt_up = pk_up; m_down_dir = pk_dn;
                    m_up   = pk_up ? FW'(pk_t) : '0;
                    m_down = pk_up ? '0 : FW'(pk_t);
                    m_issue = m_cyc;
                    m_phase = 2;
                end
                2: begin
                    if (rise) begin
                        if (m_tgt_up) nu[m_tgt] = 1'b0; else nd[m_tgt] = 1'b0;
                        m_cur = m_tgt; m_up = '0; m_down = '0; m_phase = 3;
                    end else if (m_cyc - m_issue == TOUT) begin
                        m_to = 1'b1; m_up = '0; m_down = '0; m_phase = 0;
                    end
                end
                default: if (!door) m_phase = 0;
            endcase
            nu[0] = 1'b0; nd[0] = 1'b0;
            m_pu = nu; m_pd = nd; m_door_prev = door;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n && armed) begin
            chk("up_bus",    64'(o_up),        64'(m_up));
            chk("down_bus",  64'(o_down),      64'(m_down));
            chk("up_lamp",   64'(o_up_lamp),   64'(m_pu));
            chk("down_lamp", 64'(o_down_lamp), 64'(m_pd));
            chk("timeout",   64'(o_timeout),   64'(m_to));
            chk("exclusive", 64'((o_up != '0) && (o_down != '0)), 64'd0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input string name, input int fl, input bit is_up);
        int n;
        n = 0;
        while (o_up == '0 && o_down == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(is_up ? o_up : o_down), 64'(fl));
        chk({name, "_other"}, 64'(is_up ? o_down : o_up), 64'd0);
    endtask

    task automatic serve();
        door = 1'b1;
        tick(1);
        chk("bus_after_arrival", 64'({o_up, o_down}), 64'd0);
        door = 1'b0;
        tick(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        hall_up = '0; hall_down = '0; ready = 1'b1; door = 1'b0; rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_up",   64'(o_up), 64'd0);
        chk("rst_down", 64'(o_down), 64'd0);
        chk("rst_lamp", 64'({o_up_lamp, o_down_lamp}), 64'd0);
        chk("rst_to",   64'(o_timeout), 64'd0);
        tick(2);
        rst_n = 1'b1;
        armed = 1'b1;
        tick(1);

        // Single call: lamp after one cycle, request after three
        hall_up = NF'(1) << 5;
        tick(1);
        hall_up = '0;
        chk("single_lamp", 64'(o_up_lamp[5]), 64'd1);
        tick(1);
        chk("single_early", 64'(o_up), 64'd0);
        tick(1);
        chk("single_req", 64'(o_up), 64'd5);
        door = 1'b1;
        tick(1);
        chk("single_bus_clr", 64'(o_up), 64'd0);
        chk("single_lamp_clr", 64'(o_up_lamp[5]), 64'd0);
        door = 1'b0;
        tick(2);

        // SCAN order from floor 5 going up
        hall_up = (NF'(1) << 3) | (NF'(1) << 9);
        hall_down = NF'(1) << 7;
        tick(1);
        hall_up = '0; hall_down = '0;
        wait_req("scan_1st", 9, 1'b1); serve();
        wait_req("scan_2nd", 7, 1'b0); serve();
        wait_req("scan_3rd", 3, 1'b1); serve();

        // Timeout and retry
        hall_down = NF'(1) << 4;
        tick(1);
        hall_down = '0;
        wait_req("to_issue", 4, 1'b0);
        tick(TOUT - 1);
        chk("to_not_yet", 64'(o_timeout), 64'd0);
        chk("to_hold", 64'(o_down), 64'd4);
        tick(1);
        chk("to_pulse", 64'(o_timeout), 64'd1);
        chk("to_bus_clr", 64'(o_down), 64'd0);
        chk("to_lamp_kept", 64'(o_down_lamp[4]), 64'd1);
        wait_req("to_reissue", 4, 1'b0);
        serve();

        // Press during service, then press coincident with arrival
        hall_up = NF'(1) << 6;
        tick(1);
        hall_up = '0;
        wait_req("svc_req", 6, 1'b1);
        hall_up = NF'(1) << 6;
        tick(1);
        hall_up = '0;
        tick(1);
        chk("svc_lamp_on", 64'(o_up_lamp[6]), 64'd1);
        door = 1'b1;
        hall_up = NF'(1) << 6;
        tick(1);
        hall_up = '0;
        chk("svc_clear_wins", 64'(o_up_lamp[6]), 64'd0);
        door = 1'b0;
        tick(4);
        chk("svc_idle", 64'({o_up, o_down}), 64'd0);

        // Floor 0 is ignored; simultaneous up/down calls stay exclusive
        hall_up = NF'(1);
        tick(1);
        hall_up = '0;
        tick(5);
        chk("f0_lamp", 64'({o_up_lamp, o_down_lamp}), 64'd0);
        chk("f0_bus", 64'({o_up, o_down}), 64'd0);
        hall_up = NF'(1) << 2;
        hall_down = NF'(1) << 8;
        tick(1);
        hall_up = '0; hall_down = '0;
        wait_req("excl_1st", 8, 1'b0); serve();
        wait_req("excl_2nd", 2, 1'b1); serve();

        // Lift not ready: call waits
        ready = 1'b0;
        hall_up = NF'(1) << 12;
        tick(1);
        hall_up = '0;
        tick(6);
        chk("nrdy_bus", 64'(o_up), 64'd0);
        chk("nrdy_lamp", 64'(o_up_lamp[12]), 64'd1);
        ready = 1'b1;
        wait_req("nrdy_req", 12, 1'b1);
        serve();

        // Reset while waiting for arrival
        hall_up = NF'(1) << 10;
        tick(1);
        hall_up = '0;
        wait_req("rst_mid_req", 10, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_up", 64'(o_up), 64'd0);
        chk("rstmid_down", 64'(o_down), 64'd0);
        chk("rstmid_lamp", 64'({o_up_lamp, o_down_lamp}), 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        chk("post_rst_bus", 64'({o_up, o_down}), 64'd0);
        chk("post_rst_lamp", 64'({o_up_lamp, o_down_lamp}), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
